// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data RAM between the CPU data port
// and a DMA/loader port. The CPU gets zero-wait access whenever it wins.
// The DMA wins when the CPU is idle, when it has waited STARVE_LIMIT cycles,
// or while it holds a locked burst. The RAM is clocked on the inverted CLK,
// so mem_q_i for the address presented in a cycle is valid before that
// cycle's rising edge.
//
// Handshake semantics:
//   - CPU: cpu_req_i asks for an access this cycle. The access is performed
//     in every cycle where cpu_req_i=1 and cpu_stall_o=0. While stalled the
//     CPU holds address, data and we.
//   - DMA: dma_req_i is a valid that is held with its address, data and we
//     until dma_gnt_o=1. The beat completes in the dma_gnt_o cycle. A granted
//     read returns data one cycle later as a one-cycle dma_rvalid_o pulse.
//   - dma_lock_i asks to keep ownership for up to BURST_MAX beats. Dropping
//     it ends the burst at the next edge.
module data_mem_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic          cpu_we_i,
  output logic          cpu_stall_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          dma_req_i,
  input  logic          dma_lock_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  input  logic          dma_we_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic [AW-1:0] mem_address_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_q_i,
  output logic          dbg_state_o
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // The beat that brings the burst count up to BURST_MAX is the last one held
  // under lock. The first beat is taken in ARB, so a burst holds exactly
  // BURST_MAX beats.
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
  // With BURST_MAX=1 the single locked beat completes in ARB, so the arbiter
  // never enters BURST.
  localparam logic CAN_BURST = (BURST_MAX > 1);

  state_t        state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic          in_burst;
  logic          dma_win;
  logic          burst_exit;

  assign cpu_rdata_o = mem_q_i;
  assign dbg_state_o = state_q;

  // Arbitration decision, next state and RAM port mux.
  always_comb begin
    in_burst      = (state_q == ST_BURST);
    dma_win       = 1'b0;
    burst_exit    = 1'b0;
    state_d       = state_q;
    cpu_stall_o   = 1'b0;
    dma_gnt_o     = 1'b0;
    mem_address_o = cpu_addr_i;
    mem_data_o    = cpu_wdata_i;
    mem_we_o      = 1'b0;

    if (in_burst) dma_win = dma_req_i;
    else          dma_win = dma_req_i & (~cpu_req_i | (starve_cnt == STARVE_MAX));

    case (state_q)
      ST_ARB: begin
        if (dma_win & dma_lock_i & CAN_BURST) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (~dma_lock_i | (dma_win & (beat_cnt == BEAT_LAST))) begin
          state_d    = ST_ARB;
          burst_exit = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase

    dma_gnt_o   = dma_win;
    cpu_stall_o = cpu_req_i & (dma_win | in_burst);

    if (dma_win) begin
      mem_address_o = dma_addr_i;
      mem_data_o    = dma_wdata_i;
    end

    // No write unless the selected port is granted; nothing is written
    // while reset is high, even mid-cycle.
    if (dma_win) mem_we_o = dma_we_i & ~RST;
    else         mem_we_o = cpu_we_i & cpu_req_i & ~cpu_stall_o & ~RST;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_ARB;
    else     state_q <= state_d;
  end

  // Starvation and burst-beat counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      // Leaving a burst clears the count so a waiting CPU wins next cycle.
      if (burst_exit | dma_win | ~dma_req_i) starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)     starve_cnt <= starve_cnt + 1'b1;

      if ((state_q == ST_ARB) && (state_d == ST_BURST)) beat_cnt <= BW'(1);
      else if (in_burst && dma_win)                     beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // DMA read return: capture RAM q at the end of the granted read cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dma_rvalid_o <= 1'b0;
      dma_rdata_o  <= '0;
    end else begin
      dma_rvalid_o <= dma_win & ~dma_we_i;
      if (dma_win & ~dma_we_i) dma_rdata_o <= mem_q_i;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the arbiter and RAM.
module tb_data_mem_arbiter;

  localparam int AW           = 12;
  localparam int DW           = 32;
  localparam int STARVE_LIMIT = 8;
  localparam int BURST_MAX    = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cpu_req, cpu_we, dma_req, dma_lock, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_stall_o, dma_gnt_o, dma_rvalid_o, mem_we_o, dbg_state_o;
  logic [DW-1:0] cpu_rdata_o, dma_rdata_o, mem_data_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] ram_q;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  data_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_we_i(cpu_we), .cpu_stall_o(cpu_stall_o), .cpu_rdata_o(cpu_rdata_o),
    .dma_req_i(dma_req), .dma_lock_i(dma_lock), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_we_i(dma_we), .dma_gnt_o(dma_gnt_o),
    .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_q_i(ram_q), .dbg_state_o(dbg_state_o)
  );

  // RAM on the inverted clock, write-first.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram_q = '0;
  end
  always @(negedge CLK) begin
    if (mem_we_o) ram[mem_address_o] <= mem_data_o;
    ram_q <= mem_we_o ? mem_data_o : ram[mem_address_o];
  end

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  int            m_wait;     // cycles the DMA has been waiting ungranted
  bit            m_burst;    // DMA currently owns the RAM under lock
  int            m_beats;    // beats taken in the current burst
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  bit            last_gnt, last_stall;

  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    m_wait = 0; m_burst = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
    last_gnt = 0; last_stall = 0;
  end

  task automatic model_cycle();
    bit            dw, stall, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    dw    = dma_req && (m_burst || !cpu_req || m_wait >= STARVE_LIMIT);
    stall = cpu_req && (dw || m_burst);
    a     = dw ? dma_addr : cpu_addr;
    d     = dw ? dma_wdata : cpu_wdata;
    we    = dw ? dma_we : (cpu_req && cpu_we && !stall);

    chk1("dma_gnt", dma_gnt_o, dw);
    chk1("cpu_stall", cpu_stall_o, stall);
    chkw("mem_addr", DW'(mem_address_o), DW'(a));
    chkw("mem_data", mem_data_o, d);
    chk1("mem_we", mem_we_o, we);
    chk1("dma_rvalid", dma_rvalid_o, m_rvalid);
    if (m_rvalid) begin
      chk1("rd_queue_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) m_rdata = exp_q.pop_front();
    end
    chkw("dma_rdata", dma_rdata_o, m_rdata);
    chkw("cpu_rdata", cpu_rdata_o, ram_q);
    chk1("burst_state", dbg_state_o, m_burst);

    // advance to next cycle
    m_rvalid = dw && !dma_we;
    if (m_rvalid) exp_q.push_back(shadow[dma_addr]);
    if (we) shadow[a] = d;
    if (dw || !dma_req) m_wait = 0;
    else if (m_wait < STARVE_LIMIT) m_wait++;
    if (!m_burst) begin
      if (dw && dma_lock && BURST_MAX > 1) begin
        m_burst = 1;
        m_beats = 1;
      end
    end else begin
      if (dw) m_beats++;
      if (!dma_lock || m_beats == BURST_MAX) begin
        m_burst = 0;
        m_wait  = 0;
      end
    end
    last_gnt   = dw;
    last_stall = stall;
  endtask

  // Compare process: inputs change at +1, RAM moves at +5, compare at +4.
  always begin
    @(posedge CLK);
    #4;
    if (RST) begin
      chk1("reset_mem_we", mem_we_o, 1'b0);
      chk1("reset_rvalid", dma_rvalid_o, 1'b0);
      chkw("reset_rdata", dma_rdata_o, '0);
      chk1("reset_state", dbg_state_o, 1'b0);
      m_wait = 0; m_burst = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
      exp_q.delete();
      last_gnt = 0; last_stall = 0;
    end else begin
      model_cycle();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int grants;
    RST = 1'b1;
    set_idle();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // T1: CPU write with no DMA
    @(posedge CLK); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = AW'(3); cpu_wdata = 32'h55;
    #3;
    chk1("t1_mem_we", mem_we_o, 1'b1);
    chkw("t1_addr", DW'(mem_address_o), 32'd3);
    chkw("t1_data", mem_data_o, 32'h55);
    chk1("t1_stall", cpu_stall_o, 1'b0);
    chk1("t1_gnt", dma_gnt_o, 1'b0);

    // T2: load 0xABCD at 10, then DMA read with CPU idle
    @(posedge CLK); #1;
    cpu_addr = AW'(10); cpu_wdata = 32'hABCD;
    @(posedge CLK); #1;
    set_idle();
    dma_req = 1; dma_addr = AW'(10);
    #3;
    chk1("t2_gnt", dma_gnt_o, 1'b1);
    @(posedge CLK); #1;
    set_idle();
    #3;
    chk1("t2_rvalid", dma_rvalid_o, 1'b1);
    chkw("t2_rdata", dma_rdata_o, 32'hABCD);
    @(posedge CLK); #3;
    chk1("t2_rvalid_pulse", dma_rvalid_o, 1'b0);

    // T3: CPU and DMA both held; DMA wins once after STARVE_LIMIT cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = AW'(i);
      dma_req = 1; dma_we = 0; dma_addr = AW'(20);
      #3;
      chk1("t3_gnt", dma_gnt_o, i == 8);
      chk1("t3_stall", cpu_stall_o, i == 8);
    end
    idle_cycle();

    // T4: locked DMA writes against a requesting CPU
    grants = 0;
    for (int i = 0; i < 60 && grants < 6; i++) begin
      @(posedge CLK); #1;
      cpu_req = 1; cpu_we = 1; cpu_addr = AW'(200); cpu_wdata = $urandom;
      dma_req = 1; dma_lock = 1; dma_we = 1;
      dma_addr = AW'(100 + grants); dma_wdata = $urandom;
      #3;
      if (i <= 12) begin
        chk1("t4_gnt", dma_gnt_o, i >= 8 && i <= 11);
        chk1("t4_stall", cpu_stall_o, i >= 8 && i <= 11);
      end
      if (dma_gnt_o) grants++;
    end
    chkw("t4_grants", DW'(grants), 32'd6);
    idle_cycle();
    idle_cycle();

    // T5: async reset mid-burst with a DMA write pending
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      cpu_req = 1; cpu_we = 1; cpu_addr = AW'(300); cpu_wdata = 32'h1234;
      dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = AW'(400); dma_wdata = 32'hDEAD;
      if (i == 9) begin
        #1;
        chk1("t5_pre_we", mem_we_o, 1'b1);
        chk1("t5_pre_state", dbg_state_o, 1'b1);
        RST = 1'b1;
        #1;
        chk1("t5_we_in_reset", mem_we_o, 1'b0);
        chk1("t5_state_in_reset", dbg_state_o, 1'b0);
        chk1("t5_rvalid_in_reset", dma_rvalid_o, 1'b0);
      end
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    #3;
    chk1("t5_gnt_after", dma_gnt_o, 1'b0);
    chk1("t5_stall_after", cpu_stall_o, 1'b0);
    chk1("t5_cpu_we_after", mem_we_o, 1'b1);
    chkw("t5_addr_after", DW'(mem_address_o), 32'd300);

    // Randomized traffic obeying hold-until-accepted on both ports
    set_idle();
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK); #1;
      if (!(cpu_req && last_stall)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if (!(dma_req && !last_gnt)) begin
        dma_req   = ($urandom_range(0, 99) < 45);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = AW'($urandom_range(0, 15));
        dma_wdata = $urandom;
      end
      if ($urandom_range(0, 9) == 0) dma_lock = ~dma_lock;
    end

    set_idle();
    repeat (3) @(posedge CLK);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
